// File: rtl/aes_pipeline_stage1.sv
// AES-GCM stage 1: iterative AES-128 key expansion (one round key per cycle), then phase-tagged beat streaming.
// Optional feature: define AES_STAGE1_KEY_CACHE_EN to skip re-expansion when the same key is restarted.
module aes_pipeline_stage1 (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic [127:0]    i_key,
   input  logic [95:0]     i_iv,
   input  logic            i_valid,
   input  logic [2:0]      i_phase,
   input  logic [127:0]    i_plain_text,
   input  logic [127:0]    i_aad,
   input  logic [127:0]    i_instance_size,
   output logic            o_ready,
   output logic [1407:0]   o_key_schedule,
   output logic [95:0]     o_iv,
   output logic [127:0]    o_h,
   output logic [127:0]    o_plain_text,
   output logic [127:0]    o_aad,
   output logic [127:0]    o_instance_size,
   output logic [2:0]      o_phase
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_MARK   = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] pos;
      pos = 11'd2047 - {x, 3'b000};
      return SBOX_TBL[pos -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t        state_r;
   logic [127:0]  rk_r [0:10];
   logic [3:0]    rnd_r;
   logic [95:0]   iv_r;
   logic [127:0]  h_r;
   logic [127:0]  pt_r;
   logic [127:0]  aad_r;
   logic [127:0]  len_r;
   logic [2:0]    phase_r;

   logic [3:0]    prev_idx_s;
   logic [127:0]  rk_prev_s;
   logic [127:0]  rk_next_s;
   logic [31:0]   temp_s;
   logic [31:0]   n0_s, n1_s, n2_s, n3_s;
   logic          ready_s;
   logic          beat_ok_s;
   logic          cache_hit_s;

`ifdef AES_STAGE1_KEY_CACHE_EN
   // rk_r[0] always holds the most recent key, so a valid flag is all the cache needs.
   logic          cache_vld_r;
   assign cache_hit_s = cache_vld_r && (i_key == rk_r[0]);
`else
   assign cache_hit_s = 1'b0;
`endif

   // Ready depends on state alone.
   assign ready_s = (state_r == ST_IDLE) || (state_r == ST_RUN);

   // Next round key from the previous one.
   always_comb begin
      prev_idx_s = 4'd0;
      if ((rnd_r >= 4'd1) && (rnd_r <= 4'd10)) begin
         prev_idx_s = rnd_r - 4'd1;
      end else begin
         prev_idx_s = 4'd0;
      end
      rk_prev_s = rk_r[prev_idx_s];
      temp_s    = sub_word({rk_prev_s[23:0], rk_prev_s[31:24]}) ^ {rcon(rnd_r), 24'h000000};
      n0_s      = rk_prev_s[127:96] ^ temp_s;
      n1_s      = rk_prev_s[95:64] ^ n0_s;
      n2_s      = rk_prev_s[63:32] ^ n1_s;
      n3_s      = rk_prev_s[31:0] ^ n2_s;
      rk_next_s = {n0_s, n1_s, n2_s, n3_s};
   end

   // Beat acceptance: RUN only, start takes priority, illegal phase codes are dropped.
   always_comb begin
      beat_ok_s = 1'b0;
      if ((state_r == ST_RUN) && i_valid && !i_start &&
          ((i_phase == 3'b001) || (i_phase == 3'b010) || (i_phase == 3'b011))) begin
         beat_ok_s = 1'b1;
      end else begin
         beat_ok_s = 1'b0;
      end
   end

   // Control FSM, key schedule and registered beat outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         rnd_r   <= 4'd0;
         for (int r = 0; r < 11; r++) rk_r[r] <= 128'd0;
         iv_r    <= 96'd0;
         h_r     <= 128'd0;
         pt_r    <= 128'd0;
         aad_r   <= 128'd0;
         len_r   <= 128'd0;
         phase_r <= 3'b111;
`ifdef AES_STAGE1_KEY_CACHE_EN
         cache_vld_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE, ST_RUN: begin
               if (i_start) begin
                  iv_r  <= i_iv;
                  pt_r  <= 128'd0;
                  aad_r <= 128'd0;
                  len_r <= 128'd0;
                  if (cache_hit_s) begin
                     state_r <= ST_MARK;
                     phase_r <= 3'b000;
                  end else begin
                     state_r <= ST_EXPAND;
                     phase_r <= 3'b111;
                     rk_r[0] <= i_key;
                     h_r     <= i_key;
                     rnd_r   <= 4'd1;
`ifdef AES_STAGE1_KEY_CACHE_EN
                     cache_vld_r <= 1'b0;
`endif
                  end
               end else if (beat_ok_s) begin
                  pt_r    <= i_plain_text;
                  aad_r   <= i_aad;
                  len_r   <= i_instance_size;
                  phase_r <= i_phase;
               end else begin
                  pt_r    <= 128'd0;
                  aad_r   <= 128'd0;
                  len_r   <= 128'd0;
                  phase_r <= 3'b111;
               end
            end
            ST_EXPAND: begin
               for (int r = 1; r < 11; r++) begin
                  if (rnd_r == 4'(r)) rk_r[r] <= rk_next_s;
               end
               if (rnd_r == 4'd10) begin
                  state_r <= ST_MARK;
                  phase_r <= 3'b000;
`ifdef AES_STAGE1_KEY_CACHE_EN
                  cache_vld_r <= 1'b1;
`endif
               end else begin
                  rnd_r   <= rnd_r + 4'd1;
                  phase_r <= 3'b111;
               end
            end
            ST_MARK: begin
               state_r <= ST_RUN;
               phase_r <= 3'b111;
            end
            default: begin
               state_r <= ST_IDLE;
               phase_r <= 3'b111;
            end
         endcase
      end
   end

   for (genvar g = 0; g < 11; g++) begin : g_sched
      assign o_key_schedule[128*g +: 128] = rk_r[g];
   end

   assign o_ready         = ready_s;
   assign o_iv            = iv_r;
   assign o_h             = h_r;
   assign o_plain_text    = pt_r;
   assign o_aad           = aad_r;
   assign o_instance_size = len_r;
   assign o_phase         = phase_r;

endmodule
